// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: result and broadcast
// structs, FU index names, sizing constants and the round-robin index helper.
package writeback_arbiter_pkg;

  localparam int unsigned N_FU       = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned IDX_W      = $clog2(N_FU);

  typedef enum logic [IDX_W-1:0] {
    FU_ALU = 0,
    FU_MUL = 1,
    FU_LSU = 2,
    FU_TC  = 3
  } fu_idx_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  tag;
  } fu_result_t;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  tag;
  } wb_t;

  // (base + k) mod N_FU, used to walk FU indices starting at the round-robin pointer.
  function automatic logic [IDX_W-1:0] rr_add(input logic [IDX_W-1:0] base,
                                              input int unsigned k);
    int unsigned s;
    s = (32'(base) + k) % N_FU;
    return IDX_W'(s);
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Completion-port and writeback bus between the functional units / issue stage
// and the writeback arbiter.
//
// Handshake: a result on FU port i transfers in a cycle where fu_valid[i] and
// fu_ready[i] are both high. fu_ready[i] does not depend on fu_valid[i]; the
// producer may hold or change its payload while fu_ready[i] is low.
// wb is a registered broadcast with no back-pressure: wb.valid is high for one
// cycle per result (longer only while freeze holds it).
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  logic [N_FU-1:0]             fu_valid;
  logic [N_FU-1:0][REG_W-1:0]  fu_rd;
  logic [N_FU-1:0][DATA_W-1:0] fu_value;
  logic [N_FU-1:0][TAG_W-1:0]  fu_tag;
  logic [N_FU-1:0]             fu_ready;
  logic                        flush;
  logic                        freeze;
  wb_t                         wb;
  logic [IDX_W-1:0]            dbg_rr_ptr;

  // FU / issue side
  modport master (
    output fu_valid, fu_rd, fu_value, fu_tag, flush, freeze,
    input  fu_ready, wb, dbg_rr_ptr
  );

  // Arbiter side
  modport slave (
    input  fu_valid, fu_rd, fu_value, fu_tag, flush, freeze,
    output fu_ready, wb, dbg_rr_ptr
  );
endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// Per-FU synchronous result FIFO. Pointers wrap mod DEPTH (power of 2);
// clear empties the FIFO at the next edge.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       push,
  input  fu_result_t din,
  input  logic       pop,
  output fu_result_t dout,
  output logic       full,
  output logic       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fu_result_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage array: written on push, no reset needed since count gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers FU completions per FU, picks one per cycle
// round-robin and drives the registered wb broadcast. flush/reset discard all
// pending results; freeze holds wb, the FIFO heads and the round-robin pointer.
// Optional macro WB_BYPASS_EN: a result arriving at an empty FIFO may be granted
// in its arrival cycle and sent straight to wb without being stored.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
(
  input logic                clk,
  input logic                rst,
  writeback_arbiter_if.slave bus
);
  logic [N_FU-1:0]  full;
  logic [N_FU-1:0]  empty;
  logic [N_FU-1:0]  ready;
  logic [N_FU-1:0]  accept;
  logic [N_FU-1:0]  req;
  logic [N_FU-1:0]  fifo_push;
  logic [N_FU-1:0]  fifo_pop;
  fu_result_t       in_res [N_FU];
  fu_result_t       head   [N_FU];
  fu_result_t       gnt_res;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             advance;
  logic [IDX_W-1:0] rr_ptr;
  wb_t              wb_q;
`ifdef WB_BYPASS_EN
  logic [N_FU-1:0]  bypass_take;
`endif

  for (genvar g = 0; g < N_FU; g++) begin : g_fu
    assign in_res[g] = '{rd: bus.fu_rd[g], value: bus.fu_value[g], tag: bus.fu_tag[g]};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .clear (rst | bus.flush),
      .push  (fifo_push[g]),
      .din   (in_res[g]),
      .pop   (fifo_pop[g]),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // Acceptance uses pre-pop occupancy, so a full FIFO refuses even when it pops.
  always_comb begin
    ready  = '0;
    accept = '0;
    req    = '0;
    for (int i = 0; i < N_FU; i++) begin
      ready[i]  = !full[i] && !bus.flush && !rst;
      accept[i] = bus.fu_valid[i] && ready[i];
`ifdef WB_BYPASS_EN
      req[i]    = !empty[i] || accept[i];
`else
      req[i]    = !empty[i];
`endif
    end
  end

  // Round-robin grant: first requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N_FU; k++) begin
      if (!gnt_valid && req[rr_add(rr_ptr, k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rr_add(rr_ptr, k);
      end
    end
  end

  // Pop/push control and selection of the granted result.
  always_comb begin
    advance  = gnt_valid && !bus.freeze && !bus.flush && !rst;
    fifo_pop = '0;
    for (int i = 0; i < N_FU; i++) begin
      fifo_pop[i] = advance && (gnt_idx == IDX_W'(i)) && !empty[i];
    end
`ifdef WB_BYPASS_EN
    bypass_take = '0;
    for (int i = 0; i < N_FU; i++) begin
      bypass_take[i] = advance && (gnt_idx == IDX_W'(i)) && empty[i];
    end
    fifo_push = accept & ~bypass_take;
    gnt_res   = empty[gnt_idx] ? in_res[gnt_idx] : head[gnt_idx];
`else
    fifo_push = accept;
    gnt_res   = head[gnt_idx];
`endif
  end

  // Registered writeback broadcast and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wb_q   <= '0;
      rr_ptr <= '0;
    end else if (!bus.freeze) begin
      if (gnt_valid) begin
        wb_q   <= '{valid: 1'b1, rd: gnt_res.rd, value: gnt_res.value, tag: gnt_res.tag};
        rr_ptr <= rr_add(gnt_idx, 1);
      end else begin
        wb_q   <= '0;
      end
    end
  end

  assign bus.fu_ready   = ready;
  assign bus.wb         = wb_q;
  assign bus.dbg_rr_ptr = rr_ptr;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a per-cycle vector table (inputs plus
// expected fu_ready and wb), then hand-written latency and mid-flight reset
// sequences. Build with WB_BYPASS_EN defined to exercise the bypass path.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  typedef struct {
    logic                  rst;
    logic                  flush;
    logic                  freeze;
    logic [N_FU-1:0]       valid;
    fu_result_t [N_FU-1:0] res;
    logic [N_FU-1:0]       exp_ready;
    wb_t                   exp_wb;
  } vec_t;

  localparam logic [N_FU-1:0] RDY_ALL = 4'b1111;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];
  fu_result_t zr;
  wb_t        zw;

  writeback_arbiter_if bus ();

  writeback_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fu_result_t mk_r(input logic [REG_W-1:0] rd,
                                      input logic [DATA_W-1:0] value,
                                      input logic [TAG_W-1:0] tag);
    return '{rd: rd, value: value, tag: tag};
  endfunction

  function automatic wb_t mk_w(input logic [REG_W-1:0] rd,
                               input logic [DATA_W-1:0] value,
                               input logic [TAG_W-1:0] tag);
    return '{valid: 1'b1, rd: rd, value: value, tag: tag};
  endfunction

  task automatic add(input logic r, input logic fl, input logic fz,
                     input logic [N_FU-1:0] v,
                     input fu_result_t a, input fu_result_t b,
                     input fu_result_t c, input fu_result_t d,
                     input logic [N_FU-1:0] er, input wb_t ew);
    vec_t t;
    t.rst = r; t.flush = fl; t.freeze = fz; t.valid = v;
    t.res[0] = a; t.res[1] = b; t.res[2] = c; t.res[3] = d;
    t.exp_ready = er; t.exp_wb = ew;
    vecs.push_back(t);
  endtask

  // Driver: inputs change on the falling edge only.
  task automatic drive(input vec_t t);
    rst        = t.rst;
    bus.flush  = t.flush;
    bus.freeze = t.freeze;
    bus.fu_valid = t.valid;
    for (int i = 0; i < N_FU; i++) begin
      bus.fu_rd[i]    = t.res[i].rd;
      bus.fu_value[i] = t.res[i].value;
      bus.fu_tag[i]   = t.res[i].tag;
    end
  endtask

  task automatic check_ready(input string name, input logic [N_FU-1:0] exp);
    total++;
    if (bus.fu_ready !== exp) begin
      bad++;
      $display("FAIL %s fu_ready got=%b exp=%b", name, bus.fu_ready, exp);
    end
  endtask

  task automatic check_wb(input string name, input wb_t exp);
    total++;
    if (bus.wb !== exp) begin
      bad++;
      $display("FAIL %s wb got=%h exp=%h", name, bus.wb, exp);
    end
  endtask

  initial begin
    int  lat;
    bit  found;
    vec_t idle;

    total = 0;
    bad   = 0;
    zr    = '0;
    zw    = '0;
    idle  = '{rst: 1'b0, flush: 1'b0, freeze: 1'b0, valid: '0, res: '0,
              exp_ready: '0, exp_wb: '0};
    rst   = 1'b1;
    bus.flush = 1'b0; bus.freeze = 1'b0; bus.fu_valid = '0;
    bus.fu_rd = '0; bus.fu_value = '0; bus.fu_tag = '0;
    @(posedge clk);

    // Reset: two cycles held, ready low, wb idle; then all ready.
    add(1, 0, 0, 4'b0000, zr, zr, zr, zr, 4'b0000, zw);
    add(1, 0, 0, 4'b0000, zr, zr, zr, zr, 4'b0000, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, zw);
`ifndef WB_BYPASS_EN
    // Single result, latency 2, valid for exactly one cycle.
    add(0, 0, 0, 4'b0001, mk_r(5, 32'hDEADBEEF, 3), zr, zr, zr, RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(5, 32'hDEADBEEF, 3));
    // Flush idle pipe: ready drops in the flush cycle, rr_ptr back to 0.
    add(0, 1, 0, 4'b0000, zr, zr, zr, zr, 4'b0000, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, zw);
    // Fairness: all four at once drain FU0..FU3.
    add(0, 0, 0, 4'b1111, mk_r(1, 32'h11, 1), mk_r(2, 32'h22, 2),
        mk_r(3, 32'h33, 3), mk_r(4, 32'h44, 4), RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(1, 32'h11, 1));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(2, 32'h22, 2));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(3, 32'h33, 3));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(4, 32'h44, 4));
    // FU2 and FU0 together after wrap: FU0 first.
    add(0, 0, 0, 4'b0101, mk_r(6, 32'h66, 6), zr, mk_r(7, 32'h77, 7), zr, RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(6, 32'h66, 6));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(7, 32'h77, 7));
    // Back-pressure: frozen FU1 fills after two, third refused until a pop.
    add(0, 0, 1, 4'b0010, zr, mk_r(8, 32'h88, 8), zr, zr, RDY_ALL, zw);
    add(0, 0, 1, 4'b0010, zr, mk_r(9, 32'h99, 9), zr, zr, RDY_ALL, zw);
    add(0, 0, 1, 4'b0010, zr, mk_r(10, 32'hAA, 10), zr, zr, 4'b1101, zw);
    add(0, 0, 0, 4'b0010, zr, mk_r(10, 32'hAA, 10), zr, zr, 4'b1101, zw);
    add(0, 0, 0, 4'b0010, zr, mk_r(10, 32'hAA, 10), zr, zr, RDY_ALL, mk_w(8, 32'h88, 8));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(9, 32'h99, 9));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(10, 32'hAA, 10));
    // Flush while frozen with a held valid wb and three entries pending.
    add(0, 0, 0, 4'b0101, mk_r(11, 32'h1B, 11), zr, mk_r(12, 32'h1C, 12), zr, RDY_ALL, zw);
    add(0, 0, 0, 4'b0001, mk_r(13, 32'h1D, 13), zr, zr, zr, RDY_ALL, zw);
    add(0, 0, 1, 4'b0000, zr, zr, zr, zr, 4'b1110, mk_w(12, 32'h1C, 12));
    add(0, 0, 1, 4'b0000, zr, zr, zr, zr, 4'b1110, mk_w(12, 32'h1C, 12));
    add(0, 0, 1, 4'b1000, zr, zr, zr, mk_r(14, 32'h1E, 14), 4'b1110, mk_w(12, 32'h1C, 12));
    add(0, 1, 1, 4'b1111, mk_r(1, 32'h1, 1), mk_r(2, 32'h2, 2),
        mk_r(3, 32'h3, 3), mk_r(4, 32'h4, 4), 4'b0000, mk_w(12, 32'h1C, 12));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, zw);
    // After flush rr_ptr=0: FU1 precedes FU3; rd=0 passes through.
    add(0, 0, 0, 4'b1010, zr, mk_r(15, 32'h1F, 15), zr, mk_r(0, 32'h20, 5), RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(15, 32'h1F, 15));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(0, 32'h20, 5));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, zw);
`else
    // Bypass: empty FIFO, result on wb one cycle later.
    add(0, 0, 0, 4'b1000, zr, zr, zr, mk_r(1, 32'h11, 1), RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(1, 32'h11, 1));
    // Stored entry (under freeze) drains before a newer arrival.
    add(0, 0, 1, 4'b1000, zr, zr, zr, mk_r(2, 32'h22, 2), RDY_ALL, zw);
    add(0, 0, 0, 4'b1000, zr, zr, zr, mk_r(3, 32'h33, 3), RDY_ALL, zw);
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(2, 32'h22, 2));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, mk_w(3, 32'h33, 3));
    add(0, 0, 0, 4'b0000, zr, zr, zr, zr, RDY_ALL, zw);
`endif

    // Table replay: drive on falling edge, sample 1 time unit later.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_ready($sformatf("row%0d", i), vecs[i].exp_ready);
      check_wb($sformatf("row%0d", i), vecs[i].exp_wb);
    end

    // Latency sequence: one FU2 result into an idle arbiter, bounded wait.
    @(negedge clk);
    drive(idle);
    bus.fu_valid[2] = 1'b1;
    bus.fu_rd[2] = 5'd3; bus.fu_value[2] = 32'h5A5A_0001; bus.fu_tag[2] = 4'd9;
    #1;
    check_ready("lat_accept", RDY_ALL);
    found = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.fu_valid = '0;
      #1;
      if (!found && bus.wb.valid) begin
        found = 1'b1;
        lat   = c;
        check_wb("lat_data", mk_w(3, 32'h5A5A_0001, 9));
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL lat_timeout wb.valid never seen within 6 cycles");
    end else begin
`ifdef WB_BYPASS_EN
      if (lat != 1) begin bad++; $display("FAIL lat_cycles got=%0d exp=1", lat); end
`else
      if (lat != 2) begin bad++; $display("FAIL lat_cycles got=%0d exp=2", lat); end
`endif
    end
    check_wb("lat_after", zw);

    // Reset mid-flight: pending results must be discarded.
    @(negedge clk);
    bus.fu_valid = 4'b0011;
    bus.fu_rd[0] = 5'd7; bus.fu_value[0] = 32'h0BAD_0000; bus.fu_tag[0] = 4'd1;
    bus.fu_rd[1] = 5'd8; bus.fu_value[1] = 32'h0BAD_0001; bus.fu_tag[1] = 4'd2;
    #1;
    check_ready("rst_pre", RDY_ALL);
    @(negedge clk);
    bus.fu_valid = '0;
    rst = 1'b1;
    #1;
    check_ready("rst_hold", 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_wb("rst_wb", zw);
    check_ready("rst_rdy", RDY_ALL);
    total++;
    if (bus.dbg_rr_ptr !== '0) begin
      bad++;
      $display("FAIL rst_rr rr_ptr got=%0d exp=0", bus.dbg_rr_ptr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check_wb($sformatf("rst_drain%0d", c), zw);
    end

    // Report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
